multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle processor main controller: Moore FSM with registered strobes.
// Opcode/function decode, ALU control and PC enable are resolved here.
`timescale 1ns/100ps
module multicycle_control #(
    parameter bit BNE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCEn,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    state_t     state_q;
    state_t     state_n;
    logic       run_q;

    logic       irwrite_q;
    logic       memwrite_q;
    logic       regwrite_q;
    logic       pcwrite_q;
    logic       branch_q;
    logic       branchne_q;
    logic       iord_q;
    logic       regdst_q;
    logic       memtoreg_q;
    logic       alusrca_q;
    logic [1:0] alusrcb_q;
    logic [1:0] pcsrc_q;
    logic [1:0] aluop_q;

    logic       nx_irwrite;
    logic       nx_memwrite;
    logic       nx_regwrite;
    logic       nx_pcwrite;
    logic       nx_branch;
    logic       nx_branchne;
    logic       nx_iord;
    logic       nx_regdst;
    logic       nx_memtoreg;
    logic       nx_alusrca;
    logic [1:0] nx_alusrcb;
    logic [1:0] nx_pcsrc;
    logic [1:0] nx_aluop;

    logic       is_lwsw;
    logic       is_rtype;
    logic       is_beq;
    logic       is_bne;
    logic       is_addi;
    logic       is_j;
    logic       op_legal;

    logic [2:0] alu_fn;
    logic       funct_ok;

    // Opcode class flags; BNE only counts when the build enables it.
    always_comb begin
        is_lwsw  = (Op == OP_LW) || (Op == OP_SW);
        is_rtype = (Op == OP_RTYPE);
        is_beq   = (Op == OP_BEQ);
        is_bne   = BNE_EN && (Op == OP_BNE);
        is_addi  = (Op == OP_ADDI);
        is_j     = (Op == OP_J);
        op_legal = is_lwsw | is_rtype | is_beq
                 | is_bne | is_addi | is_j;
    end

    // Next state; the first edge out of reset holds FETCH to load its outputs.
    always_comb begin
        state_n = FETCH;
        if (run_q) begin
            case (state_q)
                FETCH:   state_n = DECODE;
                DECODE: begin
                    unique case (1'b1)
                        is_lwsw:         state_n = MEMADR;
                        is_rtype:        state_n = EXECUTE;
                        is_beq | is_bne: state_n = BRANCH;
                        is_addi:         state_n = ADDIEX;
                        is_j:            state_n = JUMP;
                        default:         state_n = FETCH;
                    endcase
                end
                MEMADR:  state_n = (Op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   state_n = MEMWB;
                EXECUTE: state_n = ALUWB;
                ADDIEX:  state_n = ADDIWB;
                default: state_n = FETCH;
            endcase
        end
    end

    // Output values belonging to the state being entered.
    always_comb begin
        nx_irwrite  = 1'b0;
        nx_memwrite = 1'b0;
        nx_regwrite = 1'b0;
        nx_pcwrite  = 1'b0;
        nx_branch   = 1'b0;
        nx_branchne = 1'b0;
        nx_iord     = 1'b0;
        nx_regdst   = 1'b0;
        nx_memtoreg = 1'b0;
        nx_alusrca  = 1'b0;
        nx_alusrcb  = 2'b00;
        nx_pcsrc    = 2'b00;
        nx_aluop    = ALUOP_ADD;
        case (state_n)
            FETCH: begin
                nx_irwrite = 1'b1;
                nx_pcwrite = 1'b1;
                nx_alusrcb = 2'b01;
            end
            DECODE: nx_alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                nx_alusrca = 1'b1;
                nx_alusrcb = 2'b10;
            end
            MEMRD: nx_iord = 1'b1;
            MEMWR: begin
                nx_iord     = 1'b1;
                nx_memwrite = 1'b1;
            end
            MEMWB: begin
                nx_memtoreg = 1'b1;
                nx_regwrite = 1'b1;
            end
            EXECUTE: begin
                nx_alusrca = 1'b1;
                nx_aluop   = ALUOP_FN;
            end
            ALUWB: begin
                nx_regdst   = 1'b1;
                nx_regwrite = 1'b1;
            end
            ADDIWB: nx_regwrite = 1'b1;
            BRANCH: begin
                nx_alusrca  = 1'b1;
                nx_aluop    = ALUOP_SUB;
                nx_pcsrc    = 2'b01;
                nx_branch   = is_beq;
                nx_branchne = is_bne;
            end
            JUMP: begin
                nx_pcsrc   = 2'b10;
                nx_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            run_q      <= 1'b0;
            irwrite_q  <= 1'b0;
            memwrite_q <= 1'b0;
            regwrite_q <= 1'b0;
            pcwrite_q  <= 1'b0;
            branch_q   <= 1'b0;
            branchne_q <= 1'b0;
            iord_q     <= 1'b0;
            regdst_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrca_q  <= 1'b0;
            alusrcb_q  <= 2'b00;
            pcsrc_q    <= 2'b00;
            aluop_q    <= ALUOP_ADD;
        end else begin
            state_q    <= state_n;
            run_q      <= 1'b1;
            irwrite_q  <= nx_irwrite;
            memwrite_q <= nx_memwrite;
            regwrite_q <= nx_regwrite;
            pcwrite_q  <= nx_pcwrite;
            branch_q   <= nx_branch;
            branchne_q <= nx_branchne;
            iord_q     <= nx_iord;
            regdst_q   <= nx_regdst;
            memtoreg_q <= nx_memtoreg;
            alusrca_q  <= nx_alusrca;
            alusrcb_q  <= nx_alusrcb;
            pcsrc_q    <= nx_pcsrc;
            aluop_q    <= nx_aluop;
        end
    end

    // R-type function field to ALU operation; unknown codes fall back to add.
    always_comb begin
        alu_fn   = 3'b010;
        funct_ok = 1'b1;
        case (Funct)
            6'b100000: alu_fn = 3'b010;
            6'b100010: alu_fn = 3'b110;
            6'b100100: alu_fn = 3'b000;
            6'b100101: alu_fn = 3'b001;
            6'b100110: alu_fn = 3'b011;
            6'b101010: alu_fn = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end

    // ALU operation selected by the registered ALUOp class.
    always_comb begin
        case (aluop_q)
            ALUOP_SUB: ALUControl = 3'b110;
            ALUOP_FN:  ALUControl = alu_fn;
            default:   ALUControl = 3'b010;
        endcase
    end

    // Illegal flags bad opcodes in DECODE and bad functions in EXECUTE.
    always_comb begin
        Illegal = ((state_q == DECODE) && !op_legal)
                | ((state_q == EXECUTE) && !funct_ok);
    end

    // PC enable merges unconditional writes with the resolved branch.
    always_comb begin
        PCEn = pcwrite_q
             | (branch_q & Zero)
             | (branchne_q & ~Zero);
    end

    assign State    = state_q;
    assign IRWrite  = irwrite_q;
    assign MemWrite = memwrite_q;
    assign RegWrite = regwrite_q;
    assign IorD     = iord_q;
    assign RegDst   = regdst_q;
    assign MemtoReg = memtoreg_q;
    assign ALUSrcA  = alusrca_q;
    assign ALUSrcB  = alusrcb_q;
    assign PCSrc    = pcsrc_q;

endmodule
